// File: rtl/ddr5_req_queue.sv
// DDR5 scheduler request queue: decodes requests at push time, keeps them oldest-first in a
// shifting array and presents one entry chosen by FCFS or FR-FCFS with an age-based override.
module ddr5_req_queue #(
    parameter int DEPTH     = 16,
    parameter int FRFCFS    = 1,
    parameter int AGE_LIMIT = 64,
    parameter int AGE_W     = 16,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_time,
    input  logic [3:0]    in_core,
    input  logic [1:0]    in_op,
    input  logic [33:0]   in_addr,
    input  logic [31:0]   bank_open,
    input  logic [511:0]  bank_row,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_time,
    output logic [3:0]    out_core,
    output logic [1:0]    out_op,
    output logic [15:0]   out_row,
    output logic [9:0]    out_col,
    output logic [1:0]    out_bank,
    output logic [2:0]    out_bg,
    output logic          out_chan,
    output logic [1:0]    out_byte,
    output logic          out_hit,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          drop_err
);

    typedef struct packed {
        logic [63:0]      t;
        logic [3:0]       core;
        logic [1:0]       op;
        logic [15:0]      row;
        logic [9:0]       col;
        logic [1:0]       bank;
        logic [2:0]       bg;
        logic             chan;
        logic [1:0]       byte_sel;
        logic [AGE_W-1:0] age;
    } entry_t;

    entry_t          ent [DEPTH];
    entry_t          nxt [DEPTH];
    entry_t          new_ent;
    entry_t          cur;
    logic [DEPTH-1:0] hit;
    logic [IW-1:0]   sel;
    logic            starved;
    logic            push;
    logic            pop;
    logic [CW-1:0]   keep;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && in_ready && (in_op != 2'd3);
    assign keep      = count - CW'(pop);
    assign starved   = ent[0].age >= AGE_W'(AGE_LIMIT);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = (CW'(i) < count) && bank_open[{ent[i].bg, ent[i].bank}] &&
                     (bank_row[{ent[i].bg, ent[i].bank, 4'b0000} +: 16] == ent[i].row);
        end
    end

    // Scan from the top so the lowest hitting slot wins.
    always_comb begin
        sel = '0;
        if (FRFCFS != 0 && !starved) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (hit[i]) sel = IW'(i);
            end
        end
    end

    always_comb begin
        new_ent          = '0;
        new_ent.t        = in_time;
        new_ent.core     = in_core;
        new_ent.op       = in_op;
        new_ent.row      = in_addr[33:18];
        new_ent.col      = {in_addr[17:12], in_addr[5:2]};
        new_ent.bank     = in_addr[11:10];
        new_ent.bg       = in_addr[9:7];
        new_ent.chan     = in_addr[6];
        new_ent.byte_sel = in_addr[1:0];
    end

    // Close the gap left by a pop, age the survivors, then append the new entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) nxt[i] = ent[i];
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pop && IW'(i) >= sel) nxt[i] = ent[i + 1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < keep && nxt[i].age != '1) nxt[i].age = nxt[i].age + AGE_W'(1);
            if (push && CW'(i) == keep) nxt[i] = new_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            drop_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            count    <= count + CW'(push) - CW'(pop);
            drop_err <= in_valid && in_ready && (in_op == 2'd3);
            for (int i = 0; i < DEPTH; i++) ent[i] <= nxt[i];
        end
    end

    always_comb begin
        cur = empty ? '0 : ent[sel];
        out_time = cur.t;
        out_core = cur.core;
        out_op   = cur.op;
        out_row  = cur.row;
        out_col  = cur.col;
        out_bank = cur.bank;
        out_bg   = cur.bg;
        out_chan = cur.chan;
        out_byte = cur.byte_sel;
        out_hit  = !empty && hit[sel];
    end

endmodule

// File: tb/tb_ddr5_req_queue.sv
// Bench for ddr5_req_queue: directed scenarios plus a randomized run against a queue-based
// reference model of the FCFS / FR-FCFS selection rules.
module tb_ddr5_req_queue;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [63:0]  in_time = '0;
    logic [3:0]   in_core = '0;
    logic [1:0]   in_op = '0;
    logic [33:0]  in_addr = '0;
    logic [31:0]  bank_open = '0;
    logic [511:0] bank_row = '0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [63:0]  out_time;
    logic [3:0]   out_core;
    logic [1:0]   out_op;
    logic [15:0]  out_row;
    logic [9:0]   out_col;
    logic [1:0]   out_bank;
    logic [2:0]   out_bg;
    logic         out_chan;
    logic [1:0]   out_byte;
    logic         out_hit;
    logic [4:0]   count;
    logic         full;
    logic         empty;
    logic         drop_err;

    always #5 clk = ~clk;

    ddr5_req_queue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_time(in_time), .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
        .bank_open(bank_open), .bank_row(bank_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_time(out_time), .out_core(out_core), .out_op(out_op),
        .out_row(out_row), .out_col(out_col), .out_bank(out_bank), .out_bg(out_bg),
        .out_chan(out_chan), .out_byte(out_byte), .out_hit(out_hit), .count(count),
        .full(full), .empty(empty), .drop_err(drop_err)
    );

    typedef struct {
        logic [63:0] t;
        logic [3:0]  core;
        logic [1:0]  op;
        logic [33:0] addr;
        int          age;
    } req_t;

    req_t mq[$];
    int   checks = 0;
    int   passed = 0;
    bit   exp_drop = 0;

    function automatic logic [15:0] f_row(logic [33:0] a);  return a[33:18]; endfunction
    function automatic logic [9:0]  f_col(logic [33:0] a);  return {a[17:12], a[5:2]}; endfunction
    function automatic logic [1:0]  f_bank(logic [33:0] a); return a[11:10]; endfunction
    function automatic logic [2:0]  f_bg(logic [33:0] a);   return a[9:7]; endfunction
    function automatic logic        f_chan(logic [33:0] a); return a[6]; endfunction
    function automatic logic [1:0]  f_byte(logic [33:0] a); return a[1:0]; endfunction

    function automatic bit is_hit(req_t e);
        int b;
        b = {f_bg(e.addr), f_bank(e.addr)};
        return bank_open[b] && (bank_row[b*16 +: 16] == f_row(e.addr));
    endfunction

    function automatic int exp_sel();
        if (mq.size() == 0) return -1;
        if (mq[0].age >= 64) return 0;
        foreach (mq[i]) if (is_hit(mq[i])) return i;
        return 0;
    endfunction

    task automatic tick();
        bit push, drop, pop;
        int s;
        push = in_valid && mq.size() < 16 && in_op != 2'd3;
        drop = in_valid && mq.size() < 16 && in_op == 2'd3;
        pop  = mq.size() > 0 && out_ready;
        s    = exp_sel();
        @(posedge clk);
        if (pop) mq.delete(s);
        foreach (mq[i]) if (mq[i].age < 65535) mq[i].age++;
        if (push) mq.push_back('{in_time, in_core, in_op, in_addr, 0});
        exp_drop = drop;
        #1;
    endtask

    task automatic drive(bit v, logic [1:0] op, logic [33:0] a, bit rdy);
        in_valid  = v;
        in_op     = op;
        in_addr   = a;
        in_time   = {$urandom, $urandom};
        in_core   = 4'($urandom);
        out_ready = rdy;
    endtask

    task automatic do_reset();
        drive(0, 0, '0, 0);
        rst_n = 0;
        #3;
        @(negedge clk);
        rst_n = 1;
        mq.delete();
        exp_drop = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #2;
        checks++; if (count !== 0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        checks++; if (empty !== 1 || full !== 0) $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); else passed++;
        checks++; if (out_valid !== 0 || in_ready !== 1) $display("FAIL reset_hs got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); else passed++;
        checks++; if (out_row !== 0 || out_time !== 0 || drop_err !== 0) $display("FAIL reset_out got row=%h time=%h drop=%b want 0", out_row, out_time, drop_err); else passed++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_fill();
        drive(1, 0, 34'h0_0004_0000, 0);
        #1;
        checks++; if (out_valid !== 0) $display("FAIL no_bypass got %b want 0", out_valid); else passed++;
        tick();
        drive(1, 0, 34'h0_0008_0000, 0); tick();
        drive(1, 0, 34'h0_000C_0000, 0); tick();
        drive(0, 0, '0, 0);
        #1;
        checks++; if (count !== 3) $display("FAIL fill_count got %0d want 3", count); else passed++;
        checks++; if (out_row !== 16'd1) $display("FAIL fill_oldest got %0d want 1", out_row); else passed++;
        checks++; if (empty !== 0 || full !== 0) $display("FAIL fill_flags got empty=%b full=%b want 0 0", empty, full); else passed++;
    endtask

    task automatic test_frfcfs();
        bank_open = 32'h1;
        bank_row[15:0] = 16'd3;
        #1;
        checks++; if (out_row !== 16'd3 || out_hit !== 1) $display("FAIL frfcfs_sel got row=%0d hit=%b want 3 1", out_row, out_hit); else passed++;
        out_ready = 1;
        tick();
        out_ready = 0;
        bank_open = 32'h0;
        #1;
        checks++; if (count !== 2 || out_row !== 16'd1) $display("FAIL frfcfs_rest got count=%0d row=%0d want 2 1", count, out_row); else passed++;
        checks++; if (out_hit !== 0) $display("FAIL frfcfs_nohit got %b want 0", out_hit); else passed++;
        bank_open = 32'h1;
    endtask

    task automatic test_starvation();
        bit forced_seen = 0;
        int s;
        drive(1, 0, 34'h0_000C_0000, 0);
        tick();
        for (int n = 0; n < 200 && !forced_seen; n++) begin
            drive(1, 0, 34'h0_000C_0000, 1);
            #1;
            s = exp_sel();
            checks++; if (out_row !== f_row(mq[s].addr)) $display("FAIL starve_sel got %0d want %0d", out_row, f_row(mq[s].addr)); else passed++;
            if (mq[0].age >= 64) begin
                forced_seen = 1;
                checks++; if (out_row !== 16'd1 || out_hit !== 0) $display("FAIL starve_force got row=%0d hit=%b want 1 0", out_row, out_hit); else passed++;
            end
            tick();
            checks++; if (count !== 3) $display("FAIL starve_count got %0d want 3", count); else passed++;
        end
        if (!forced_seen) begin
            checks++;
            $display("FAIL starve_timeout got no forced pop want forced within 200 cycles");
        end
        drive(0, 0, '0, 0);
    endtask

    task automatic test_full();
        do_reset();
        bank_open = '0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'($urandom_range(0, 2)), 34'({$urandom, $urandom}), 0);
            tick();
        end
        checks++; if (full !== 1 || in_ready !== 0 || count !== 16) $display("FAIL full_flags got full=%b in_ready=%b count=%0d want 1 0 16", full, in_ready, count); else passed++;
        drive(1, 0, 34'h1_2345_6789, 0);
        tick();
        checks++; if (count !== 16) $display("FAIL full_reject got %0d want 16", count); else passed++;
        drive(0, 0, '0, 1);
        tick();
        checks++; if (count !== 15 || full !== 0) $display("FAIL full_pop got count=%0d full=%b want 15 0", count, full); else passed++;
        drive(1, 1, 34'h2_0000_1234, 1);
        tick();
        checks++; if (count !== 15) $display("FAIL push_pop got %0d want 15", count); else passed++;
        checks++; if (out_time !== mq[0].t) $display("FAIL push_pop_head got %h want %h", out_time, mq[0].t); else passed++;
    endtask

    task automatic test_drop();
        drive(1, 3, 34'h0_1111_1111, 0);
        tick();
        checks++; if (count !== 15) $display("FAIL drop_count got %0d want 15", count); else passed++;
        checks++; if (drop_err !== 1) $display("FAIL drop_pulse got %b want 1", drop_err); else passed++;
        drive(0, 0, '0, 0);
        tick();
        checks++; if (drop_err !== 0) $display("FAIL drop_width got %b want 0", drop_err); else passed++;
    endtask

    task automatic test_decode();
        do_reset();
        bank_open = '0;
        drive(1, 0, 34'h3_FFFF_FFFF, 0);
        tick();
        drive(0, 0, '0, 0);
        #1;
        checks++; if (out_valid !== 1) $display("FAIL dec_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_row !== 16'hFFFF || out_col !== 10'h3FF) $display("FAIL dec_rowcol got %h %h want ffff 3ff", out_row, out_col); else passed++;
        checks++; if (out_bank !== 2'd3 || out_bg !== 3'd7 || out_chan !== 1'b1 || out_byte !== 2'd3)
            $display("FAIL dec_fields got bank=%0d bg=%0d chan=%0d byte=%0d want 3 7 1 3", out_bank, out_bg, out_chan, out_byte); else passed++;
    endtask

    task automatic test_random();
        logic [33:0] a;
        int s;
        logic [63:0] e_time;
        logic [15:0] e_row;
        logic [9:0]  e_col;
        logic [3:0]  e_misc;
        bit          e_hit;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            a = 34'({$urandom, $urandom});
            a[33:18] = 16'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 7, ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                  a, $urandom_range(0, 9) < 4);
            bank_open = $urandom;
            for (int b = 0; b < 32; b++) bank_row[b*16 +: 16] = 16'($urandom_range(0, 3));
            #1;
            s = exp_sel();
            e_time = (s < 0) ? '0 : mq[s].t;
            e_row  = (s < 0) ? '0 : f_row(mq[s].addr);
            e_col  = (s < 0) ? '0 : f_col(mq[s].addr);
            e_misc = (s < 0) ? '0 : {f_bank(mq[s].addr), f_byte(mq[s].addr)};
            e_hit  = (s >= 0) && is_hit(mq[s]);
            checks++; if (count !== mq.size()) $display("FAIL rnd_count got %0d want %0d", count, mq.size()); else passed++;
            checks++; if (out_valid !== (s >= 0) || in_ready !== (mq.size() < 16)) $display("FAIL rnd_hs got v=%b r=%b want %b %b", out_valid, in_ready, s >= 0, mq.size() < 16); else passed++;
            checks++; if (out_time !== e_time) $display("FAIL rnd_time got %h want %h", out_time, e_time); else passed++;
            checks++; if (out_row !== e_row || out_col !== e_col) $display("FAIL rnd_rowcol got %h %h want %h %h", out_row, out_col, e_row, e_col); else passed++;
            checks++; if ({out_bank, out_byte} !== e_misc) $display("FAIL rnd_bankbyte got %h want %h", {out_bank, out_byte}, e_misc); else passed++;
            checks++; if (s >= 0 && (out_core !== mq[s].core || out_op !== mq[s].op || out_bg !== f_bg(mq[s].addr) || out_chan !== f_chan(mq[s].addr)))
                $display("FAIL rnd_misc got core=%0d op=%0d bg=%0d chan=%0d", out_core, out_op, out_bg, out_chan); else passed++;
            checks++; if (out_hit !== e_hit) $display("FAIL rnd_hit got %b want %b", out_hit, e_hit); else passed++;
            checks++; if (drop_err !== exp_drop) $display("FAIL rnd_drop got %b want %b", drop_err, exp_drop); else passed++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 34'({$urandom, $urandom}), 0);
            tick();
        end
        drive(0, 0, '0, 0);
        checks++; if (count !== 5) $display("FAIL arst_pre got %0d want 5", count); else passed++;
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        checks++; if (count !== 0 || out_valid !== 0 || empty !== 1) $display("FAIL arst got count=%0d v=%b empty=%b want 0 0 1", count, out_valid, empty); else passed++;
        mq.delete();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_frfcfs();
        test_starvation();
        test_full();
        test_drop();
        test_decode();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
